// File: rtl/mem_map_pkg.sv
// rtl/mem_map_pkg.sv - shared region map, FSM encoding and master ids for the memory bus arbiter
package mem_map_pkg;

  localparam logic [3:0] RAM_REG = 4'h0;
  localparam logic [3:0] LED_REG = 4'h1;
  localparam logic [3:0] SW_REG  = 4'h3;

  localparam logic M0 = 1'b0;
  localparam logic M1 = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

  function automatic logic is_mapped(input logic [3:0] region);
    return (region == RAM_REG) || (region == LED_REG) || (region == SW_REG);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin arbiter with combinational one-hot grant
module rr_arbiter2
  import mem_map_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic [1:0] req,
  input  logic       enable,
  output logic [1:0] gnt
);

  logic last_gnt;

  // Grant follows request directly; on a tie the master that did not win last time goes first.
  always_comb begin
    gnt = 2'b00;
    if (enable) begin
      if (req == 2'b11) begin
        gnt = (last_gnt == M1) ? 2'b01 : 2'b10;
      end else begin
        gnt = req;
      end
    end
  end

  // Remember the most recent winner; reset favours M0 on the first tie.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      last_gnt <= M1;
    end else if (|gnt) begin
      last_gnt <= gnt[1];
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// rtl/mem_bus_arbiter.sv - two-master arbiter for the data RAM, LED register and switch inputs
module mem_bus_arbiter
  import mem_map_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16,
  parameter int MEM_AW = 7
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic [MEM_AW-1:0] mem_addr,
  output logic              mem_wren,
  output logic [DATA_W-1:0] mem_data,
  input  logic [DATA_W-1:0] mem_q,
  input  logic [DATA_W-1:0] sw,
  output logic [DATA_W-1:0] leds,
  output logic              bus_err
);

  state_t              state;
  state_t              state_next;
  logic [1:0]          gnt;
  logic                granted;
  logic                sel;
  logic                cmd_we;
  logic [ADDR_W-1:0]   cmd_addr;
  logic [DATA_W-1:0]   cmd_wdata;
  logic [3:0]          cmd_region;
  logic [MEM_AW-1:0]   mem_addr_q;
  logic                rd_master;
  logic [3:0]          rd_region;
  logic [DATA_W-1:0]   rd_hold;
  logic [DATA_W-1:0]   rd_data;
  logic                unused_addr_bits;

  // Address bits between the RAM index and the region field are don't-care (RAM aliases).
  assign unused_addr_bits = ^{m0_addr[ADDR_W-5:MEM_AW], m1_addr[ADDR_W-5:MEM_AW]};

  // Arbitration is only offered in IDLE and never while reset is asserted.
  rr_arbiter2 u_arb (
    .clock  (clock),
    .resetn (resetn),
    .req    ({m1_req, m0_req}),
    .enable ((state == IDLE) && resetn),
    .gnt    (gnt)
  );

  assign m0_gnt     = gnt[0];
  assign m1_gnt     = gnt[1];
  assign granted    = |gnt;
  assign sel        = gnt[1];
  assign cmd_we     = sel ? m1_we    : m0_we;
  assign cmd_addr   = sel ? m1_addr  : m0_addr;
  assign cmd_wdata  = sel ? m1_wdata : m0_wdata;
  assign cmd_region = cmd_addr[ADDR_W-1:ADDR_W-4];

  // State register.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus RAM command and read-return outputs.
  always_comb begin
    state_next = state;
    mem_addr   = mem_addr_q;
    mem_wren   = 1'b0;
    mem_data   = '0;
    bus_err    = 1'b0;
    m0_rvalid  = 1'b0;
    m1_rvalid  = 1'b0;
    m0_rdata   = '0;
    m1_rdata   = '0;
    rd_data    = (rd_region == RAM_REG) ? mem_q : rd_hold;
    case (state)
      IDLE: begin
        if (granted) begin
          mem_addr = cmd_addr[MEM_AW-1:0];
          mem_data = cmd_wdata;
          mem_wren = cmd_we && (cmd_region == RAM_REG);
          bus_err  = !is_mapped(cmd_region);
          if (!cmd_we) begin
            state_next = RD_WAIT;
          end
        end
      end
      RD_WAIT: begin
        state_next = IDLE;
        if (resetn) begin
          if (rd_master == M1) begin
            m1_rvalid = 1'b1;
            m1_rdata  = rd_data;
          end else begin
            m0_rvalid = 1'b1;
            m0_rdata  = rd_data;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // LED register, held RAM address and read context captured at the grant edge.
  always_ff @(posedge clock) begin
    if (!resetn) begin
      leds       <= '0;
      mem_addr_q <= '0;
      rd_master  <= M0;
      rd_region  <= RAM_REG;
      rd_hold    <= '0;
    end else if (granted) begin
      mem_addr_q <= cmd_addr[MEM_AW-1:0];
      if (cmd_we && (cmd_region == LED_REG)) begin
        leds <= cmd_wdata;
      end
      if (!cmd_we) begin
        rd_master <= sel;
        rd_region <= cmd_region;
        case (cmd_region)
          LED_REG: rd_hold <= leds;
          SW_REG:  rd_hold <= sw;
          default: rd_hold <= '0;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb/tb_mem_bus_arbiter.sv - self-checking bench for mem_bus_arbiter
module tb_mem_bus_arbiter;

  logic        clock;
  logic        resetn;
  logic        m0_req, m0_we, m0_gnt, m0_rvalid;
  logic [15:0] m0_addr, m0_wdata, m0_rdata;
  logic        m1_req, m1_we, m1_gnt, m1_rvalid;
  logic [15:0] m1_addr, m1_wdata, m1_rdata;
  logic [6:0]  mem_addr;
  logic        mem_wren;
  logic [15:0] mem_data, mem_q, sw, leds;
  logic        bus_err;

  int total;
  int bad;

  logic [15:0] ram     [128];
  logic [15:0] exp_ram [128];
  logic [15:0] exp_leds;
  int          model_last;
  logic        pend_read;
  int          pend_master;
  logic [15:0] pend_val;
  logic        exp_g0, exp_g1, exp_rv0, exp_rv1, exp_err, exp_wren;
  logic [15:0] exp_rd0, exp_rd1, exp_mdata;
  logic [6:0]  exp_maddr;

  mem_bus_arbiter dut (
    .clock     (clock),
    .resetn    (resetn),
    .m0_req    (m0_req),
    .m0_we     (m0_we),
    .m0_addr   (m0_addr),
    .m0_wdata  (m0_wdata),
    .m0_gnt    (m0_gnt),
    .m0_rvalid (m0_rvalid),
    .m0_rdata  (m0_rdata),
    .m1_req    (m1_req),
    .m1_we     (m1_we),
    .m1_addr   (m1_addr),
    .m1_wdata  (m1_wdata),
    .m1_gnt    (m1_gnt),
    .m1_rvalid (m1_rvalid),
    .m1_rdata  (m1_rdata),
    .mem_addr  (mem_addr),
    .mem_wren  (mem_wren),
    .mem_data  (mem_data),
    .mem_q     (mem_q),
    .sw        (sw),
    .leds      (leds),
    .bus_err   (bus_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Environment RAM: 128 x 16, synchronous read.
  always @(posedge clock) begin
    if (mem_wren) ram[mem_addr] <= mem_data;
    mem_q <= ram[mem_addr];
  end

  function automatic void model_write(input logic [15:0] addr, input logic [15:0] wd);
    if (addr[15:12] == 4'h0) exp_ram[addr[6:0]] = wd;
    else if (addr[15:12] == 4'h1) exp_leds = wd;
  endfunction

  function automatic logic [15:0] model_read(input logic [15:0] addr);
    case (addr[15:12])
      4'h0:    return exp_ram[addr[6:0]];
      4'h1:    return exp_leds;
      4'h3:    return sw;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic [15:0] rand_addr();
    logic [3:0] r;
    case ($urandom_range(0, 4))
      1:       r = 4'h1;
      2:       r = 4'h3;
      3:       r = 4'($urandom_range(0, 15));
      default: r = 4'h0;
    endcase
    return {r, 12'($urandom)};
  endfunction

  // Transaction-level prediction for the current cycle from the bench's own requests.
  task automatic model_cycle();
    int w;
    logic we;
    logic [15:0] a, d;
    exp_g0 = 0; exp_g1 = 0; exp_rv0 = 0; exp_rv1 = 0;
    exp_rd0 = 0; exp_rd1 = 0; exp_err = 0; exp_wren = 0;
    exp_maddr = 0; exp_mdata = 0;
    if (pend_read) begin
      if (pend_master == 0) begin exp_rv0 = 1; exp_rd0 = pend_val; end
      else begin exp_rv1 = 1; exp_rd1 = pend_val; end
      pend_read = 0;
    end else if (m0_req || m1_req) begin
      w  = (m0_req && m1_req) ? ((model_last == 1) ? 0 : 1) : (m1_req ? 1 : 0);
      we = w ? m1_we : m0_we;
      a  = w ? m1_addr : m0_addr;
      d  = w ? m1_wdata : m0_wdata;
      exp_g0 = (w == 0);
      exp_g1 = (w == 1);
      exp_err = !(a[15:12] == 4'h0 || a[15:12] == 4'h1 || a[15:12] == 4'h3);
      exp_wren = we && (a[15:12] == 4'h0);
      exp_maddr = a[6:0];
      exp_mdata = d;
      if (we) model_write(a, d);
      else begin
        pend_read = 1; pend_master = w; pend_val = model_read(a);
      end
      model_last = w;
    end
  endtask

  // Single-master access; returns observations for the caller to judge.
  task automatic single_access(input int m, input logic we, input logic [15:0] addr,
                               input logic [15:0] wd, output int gcyc, output logic err,
                               output logic wren, output logic rv, output logic [15:0] rd,
                               output logic other_rv);
    logic found;
    found = 0; gcyc = -1; err = 0; wren = 0; rv = 0; rd = 0; other_rv = 0;
    if (m == 0) begin m0_req = 1; m0_we = we; m0_addr = addr; m0_wdata = wd; end
    else begin m1_req = 1; m1_we = we; m1_addr = addr; m1_wdata = wd; end
    for (int i = 0; i < 4; i++) begin
      #3;
      if ((m == 0) ? m0_gnt : m1_gnt) begin
        found = 1; gcyc = i; err = bus_err; wren = mem_wren;
      end
      @(posedge clock); #1;
      if (found) break;
    end
    m0_req = 0; m1_req = 0;
    if (found) begin
      model_last = m;
      if (we) model_write(addr, wd);
      else begin
        #3;
        rv = (m == 0) ? m0_rvalid : m1_rvalid;
        rd = (m == 0) ? m0_rdata : m1_rdata;
        other_rv = (m == 0) ? m1_rvalid : m0_rvalid;
        @(posedge clock); #1;
      end
    end
  endtask

  task automatic test_reset();
    m0_req = 1; m0_we = 0; m0_addr = 16'h0000;
    #3;
    total++; if (m0_gnt !== 1'b0) begin bad++; $display("FAIL reset_gnt got=%0h exp=0", m0_gnt); end
    total++; if (leds !== 16'h0) begin bad++; $display("FAIL reset_leds got=%h exp=0000", leds); end
    total++; if (m0_rvalid !== 1'b0 || m1_rvalid !== 1'b0) begin bad++; $display("FAIL reset_rvalid got=%0h%0h exp=00", m0_rvalid, m1_rvalid); end
    total++; if (m0_rdata !== 16'h0 || m1_rdata !== 16'h0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", m0_rdata, m1_rdata); end
    total++; if (bus_err !== 1'b0 || mem_wren !== 1'b0) begin bad++; $display("FAIL reset_err_wren got=%0h%0h exp=00", bus_err, mem_wren); end
    m0_req = 0;
    @(posedge clock); #1;
    resetn = 1;
  endtask

  task automatic test_ram_write_read();
    int g; logic e, w, rv, orv; logic [15:0] rd;
    single_access(0, 1, 16'h0005, 16'hBEEF, g, e, w, rv, rd, orv);
    total++; if (g !== 0) begin bad++; $display("FAIL wr_gnt_cycle got=%0d exp=0", g); end
    total++; if (w !== 1'b1 || e !== 1'b0) begin bad++; $display("FAIL wr_wren_err got=%0h%0h exp=10", w, e); end
    single_access(0, 0, 16'h0005, 16'h0, g, e, w, rv, rd, orv);
    total++; if (g !== 0) begin bad++; $display("FAIL rd_gnt_cycle got=%0d exp=0", g); end
    total++; if (rv !== 1'b1 || orv !== 1'b0) begin bad++; $display("FAIL rd_rvalid got=%0h other=%0h exp=1/0", rv, orv); end
    total++; if (rd !== 16'hBEEF) begin bad++; $display("FAIL rd_data got=%h exp=beef", rd); end
  endtask

  task automatic test_tie();
    resetn = 0; @(posedge clock); #1; resetn = 1;
    model_last = 1; exp_leds = 0;
    m0_req = 1; m0_we = 0; m0_addr = 16'h0005;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0F85;
    #3;
    total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("FAIL tie_first got=%0h%0h exp=10", m0_gnt, m1_gnt); end
    @(posedge clock); #1; m0_req = 0; #3;
    total++; if (m0_rvalid !== 1'b1 || m1_rvalid !== 1'b0 || m1_gnt !== 1'b0) begin bad++; $display("FAIL tie_rv0 got=%0h%0h%0h exp=100", m0_rvalid, m1_rvalid, m1_gnt); end
    total++; if (m0_rdata !== model_read(16'h0005)) begin bad++; $display("FAIL tie_rd0 got=%h exp=%h", m0_rdata, model_read(16'h0005)); end
    @(posedge clock); #1; #3;
    total++; if (m1_gnt !== 1'b1) begin bad++; $display("FAIL tie_second got=%0h exp=1", m1_gnt); end
    @(posedge clock); #1; m1_req = 0; #3;
    total++; if (m1_rvalid !== 1'b1 || m0_rvalid !== 1'b0) begin bad++; $display("FAIL tie_rv1 got=%0h%0h exp=10", m1_rvalid, m0_rvalid); end
    total++; if (m1_rdata !== model_read(16'h0F85)) begin bad++; $display("FAIL tie_rd1_alias got=%h exp=%h", m1_rdata, model_read(16'h0F85)); end
    @(posedge clock); #1;
    model_last = 1;
  endtask

  task automatic test_led_sw();
    int g; logic e, w, rv, orv; logic [15:0] rd;
    single_access(1, 1, 16'h1000, 16'h00A5, g, e, w, rv, rd, orv);
    total++; if (g !== 0 || w !== 1'b0) begin bad++; $display("FAIL led_wr got=%0d/%0h exp=0/0", g, w); end
    total++; if (leds !== exp_leds) begin bad++; $display("FAIL led_value got=%h exp=%h", leds, exp_leds); end
    sw = 16'h3C3C;
    single_access(0, 0, 16'h3000, 16'h0, g, e, w, rv, rd, orv);
    total++; if (rv !== 1'b1 || rd !== 16'h3C3C) begin bad++; $display("FAIL sw_read got=%0h/%h exp=1/3c3c", rv, rd); end
    single_access(1, 0, 16'h1000, 16'h0, g, e, w, rv, rd, orv);
    total++; if (rv !== 1'b1 || rd !== exp_leds) begin bad++; $display("FAIL led_read got=%0h/%h exp=1/%h", rv, rd, exp_leds); end
    single_access(0, 1, 16'h3000, 16'hFFFF, g, e, w, rv, rd, orv);
    total++; if (leds !== exp_leds || e !== 1'b0) begin bad++; $display("FAIL sw_write_ignored got=%h/%0h exp=%h/0", leds, e, exp_leds); end
  endtask

  task automatic test_unmapped();
    int g; logic e, w, rv, orv; logic [15:0] rd;
    single_access(0, 0, 16'h7001, 16'h0, g, e, w, rv, rd, orv);
    total++; if (g !== 0 || e !== 1'b1) begin bad++; $display("FAIL unm_rd_err got=%0d/%0h exp=0/1", g, e); end
    total++; if (rv !== 1'b1 || rd !== 16'h0) begin bad++; $display("FAIL unm_rd_data got=%0h/%h exp=1/0000", rv, rd); end
    single_access(0, 1, 16'h7005, 16'h1234, g, e, w, rv, rd, orv);
    total++; if (e !== 1'b1 || w !== 1'b0) begin bad++; $display("FAIL unm_wr got=%0h/%0h exp=1/0", e, w); end
    single_access(1, 0, 16'h0005, 16'h0, g, e, w, rv, rd, orv);
    total++; if (rd !== exp_ram[5] || e !== 1'b0) begin bad++; $display("FAIL unm_no_effect got=%h exp=%h", rd, exp_ram[5]); end
  endtask

  task automatic test_reset_in_rdwait();
    m0_req = 1; m0_we = 0; m0_addr = 16'h0005;
    #3;
    total++; if (m0_gnt !== 1'b1) begin bad++; $display("FAIL rst_rd_gnt got=%0h exp=1", m0_gnt); end
    @(posedge clock); #1; m0_req = 0; resetn = 0; #3;
    total++; if (m0_rvalid !== 1'b0 || m0_rdata !== 16'h0) begin bad++; $display("FAIL rst_rv_suppressed got=%0h/%h exp=0/0000", m0_rvalid, m0_rdata); end
    @(posedge clock); #1; resetn = 1;
    exp_leds = 0; model_last = 1;
    total++; if (leds !== 16'h0) begin bad++; $display("FAIL rst_leds got=%h exp=0000", leds); end
    m0_req = 1; m0_we = 1; m0_addr = 16'h0020; m0_wdata = 16'h1111;
    m1_req = 1; m1_we = 1; m1_addr = 16'h0021; m1_wdata = 16'h2222;
    #3;
    total++; if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin bad++; $display("FAIL rst_tie got=%0h%0h exp=10", m0_gnt, m1_gnt); end
    @(posedge clock); #1; m0_req = 0; model_write(16'h0020, 16'h1111); #3;
    total++; if (m1_gnt !== 1'b1 || mem_wren !== 1'b1) begin bad++; $display("FAIL rst_second got=%0h/%0h exp=1/1", m1_gnt, mem_wren); end
    @(posedge clock); #1; m1_req = 0; model_write(16'h0021, 16'h2222);
    model_last = 1;
  endtask

  task automatic test_back_to_back();
    int k, first;
    logic g0, g1;
    k = 0; first = -1;
    m1_req = 1; m1_we = 0; m1_addr = 16'h0021;
    for (int c = 0; c < 6; c++) begin
      m0_req = 1; m0_we = 1; m0_addr = 16'h0030 + 16'(k); m0_wdata = 16'($urandom);
      #3;
      model_cycle();
      g0 = m0_gnt; g1 = m1_gnt;
      total++; if (g0 !== exp_g0 || g1 !== exp_g1) begin bad++; $display("FAIL b2b_gnt c=%0d got=%0h%0h exp=%0h%0h", c, g0, g1, exp_g0, exp_g1); end
      total++; if (mem_wren !== exp_wren) begin bad++; $display("FAIL b2b_wren c=%0d got=%0h exp=%0h", c, mem_wren, exp_wren); end
      total++; if (m1_rvalid !== exp_rv1 || m1_rdata !== exp_rd1) begin bad++; $display("FAIL b2b_rv1 c=%0d got=%0h/%h exp=%0h/%h", c, m1_rvalid, m1_rdata, exp_rv1, exp_rd1); end
      if (g1 && first < 0) first = c;
      @(posedge clock); #1;
      if (g1) m1_req = 0;
      if (g0) k++;
    end
    m0_req = 0;
    total++; if (first < 0 || first > 2) begin bad++; $display("FAIL b2b_m1_latency got=%0d exp<=2", first); end
  endtask

  task automatic test_random();
    logic g0, g1;
    for (int c = 0; c < 300; c++) begin
      if (!m0_req && $urandom_range(0, 1) == 1) begin
        m0_req = 1; m0_we = 1'($urandom_range(0, 1)); m0_addr = rand_addr(); m0_wdata = 16'($urandom);
      end
      if (!m1_req && $urandom_range(0, 1) == 1) begin
        m1_req = 1; m1_we = 1'($urandom_range(0, 1)); m1_addr = rand_addr(); m1_wdata = 16'($urandom);
      end
      if ($urandom_range(0, 7) == 0) sw = 16'($urandom);
      #3;
      total++; if (leds !== exp_leds) begin bad++; $display("FAIL rnd_leds c=%0d got=%h exp=%h", c, leds, exp_leds); end
      model_cycle();
      g0 = m0_gnt; g1 = m1_gnt;
      total++; if (g0 !== exp_g0 || g1 !== exp_g1) begin bad++; $display("FAIL rnd_gnt c=%0d got=%0h%0h exp=%0h%0h", c, g0, g1, exp_g0, exp_g1); end
      total++; if (m0_rvalid !== exp_rv0 || m0_rdata !== exp_rd0) begin bad++; $display("FAIL rnd_rv0 c=%0d got=%0h/%h exp=%0h/%h", c, m0_rvalid, m0_rdata, exp_rv0, exp_rd0); end
      total++; if (m1_rvalid !== exp_rv1 || m1_rdata !== exp_rd1) begin bad++; $display("FAIL rnd_rv1 c=%0d got=%0h/%h exp=%0h/%h", c, m1_rvalid, m1_rdata, exp_rv1, exp_rd1); end
      total++; if (bus_err !== exp_err || mem_wren !== exp_wren) begin bad++; $display("FAIL rnd_err_wren c=%0d got=%0h%0h exp=%0h%0h", c, bus_err, mem_wren, exp_err, exp_wren); end
      if (exp_wren) begin
        total++; if (mem_addr !== exp_maddr || mem_data !== exp_mdata) begin bad++; $display("FAIL rnd_mem_cmd c=%0d got=%h/%h exp=%h/%h", c, mem_addr, mem_data, exp_maddr, exp_mdata); end
      end
      @(posedge clock); #1;
      if (g0) m0_req = 0;
      if (g1) m1_req = 0;
    end
    m0_req = 0; m1_req = 0;
    #3;
    model_cycle();
    total++; if (m0_rvalid !== exp_rv0 || m1_rvalid !== exp_rv1) begin bad++; $display("FAIL rnd_drain got=%0h%0h exp=%0h%0h", m0_rvalid, m1_rvalid, exp_rv0, exp_rv1); end
    @(posedge clock); #1;
  endtask

  initial begin
    total = 0; bad = 0;
    for (int i = 0; i < 128; i++) begin ram[i] = 16'h0; exp_ram[i] = 16'h0; end
    exp_leds = 0; model_last = 1; pend_read = 0; pend_master = 0; pend_val = 0;
    resetn = 0; sw = 16'h0;
    m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
    repeat (2) @(posedge clock);
    #1;
    test_reset();
    test_ram_write_read();
    test_tie();
    test_led_sw();
    test_unmapped();
    test_reset_in_rdwait();
    test_back_to_back();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
